// File: rtl/lvds_rx_iq_framer.sv
// LVDS receive I/Q framer: hunts for the frame sync pair, checks the Q-half sync,
// assembles 32-bit frames from 2-bit pairs and pushes them into the per-band RX FIFO.
module lvds_rx_iq_framer #(
  parameter logic [1:0] SYNC_I = 2'b10,
  parameter logic [1:0] SYNC_Q = 2'b01,
  parameter int         CNT_W  = 8
) (
  input  logic             i_fast_clk,
  input  logic             i_rst_b,
  input  logic             i_enable,
  input  logic [1:0]       i_ddr_data,
  input  logic             i_clear_stats,
  output logic             o_fifo_push,
  output logic [31:0]      o_fifo_data,
  input  logic             i_fifo_full,
  output logic             o_locked,
  output logic             o_sync_err,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_sync_err_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  typedef enum logic {HUNT, FRAME} state_t;

  state_t            state_q;
  logic [3:0]        idx_q;
  logic [29:0]       shreg_q;
  logic              push_q;
  logic [31:0]       data_q;
  logic              locked_q;
  logic              sync_err_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  drop_cnt_q;

  logic [31:0]       frame_d;
  logic              q_fail_d;
  logic              done_d;
  logic              drop_d;

  // The last pair completes the frame combinationally so the push lands one cycle later.
  assign frame_d = {shreg_q, i_ddr_data};

  always_comb begin
    q_fail_d = 1'b0;
    done_d   = 1'b0;
    drop_d   = 1'b0;
    if (i_enable && state_q == FRAME) begin
      q_fail_d = (idx_q == 4'd8) && (i_ddr_data != SYNC_Q);
      done_d   = (idx_q == 4'd15);
      drop_d   = (idx_q == 4'd15) && i_fifo_full;
    end
  end

  always_ff @(posedge i_fast_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= HUNT;
      idx_q      <= 4'd0;
      shreg_q    <= '0;
      push_q     <= 1'b0;
      data_q     <= '0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      push_q     <= 1'b0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
      if (!i_enable) begin
        state_q  <= HUNT;
        idx_q    <= 4'd0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          HUNT: begin
            if (i_ddr_data == SYNC_I) begin
              shreg_q <= {28'd0, i_ddr_data};
              idx_q   <= 4'd1;
              state_q <= FRAME;
            end else begin
              // A gap after a frame means the stream is no longer continuous.
              locked_q <= 1'b0;
            end
          end
          FRAME: begin
            shreg_q <= {shreg_q[27:0], i_ddr_data};
            idx_q   <= idx_q + 4'd1;
            if (q_fail_d) begin
              sync_err_q <= 1'b1;
              locked_q   <= 1'b0;
              idx_q      <= 4'd0;
              state_q    <= HUNT;
            end else if (done_d) begin
              locked_q <= 1'b1;
              idx_q    <= 4'd0;
              state_q  <= HUNT;
              if (drop_d) begin
                overflow_q <= 1'b1;
              end else begin
                push_q <= 1'b1;
                data_q <= frame_d;
              end
            end
          end
          default: begin
            state_q <= HUNT;
            idx_q   <= 4'd0;
          end
        endcase
      end

      if (i_clear_stats) begin
        err_cnt_q  <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (q_fail_d && (err_cnt_q != '1))
          err_cnt_q <= err_cnt_q + 1'b1;
        if (drop_d && (drop_cnt_q != '1))
          drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign o_fifo_push    = push_q;
  assign o_fifo_data    = data_q;
  assign o_locked       = locked_q;
  assign o_sync_err     = sync_err_q;
  assign o_overflow     = overflow_q;
  assign o_sync_err_cnt = err_cnt_q;
  assign o_drop_cnt     = drop_cnt_q;

endmodule
